// File: rtl/msg_fifo.sv
// msg_fifo: DEPTH-slot message buffer between a 4-phase req/ack responder (i0) and initiator (o0).
// Define MSG_FIFO_REDUN_CHK_EN to ack-but-drop messages with a wrong red field and raise sticky err.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 2
`endif

// Level filter: the output follows raw_i only after CKS consecutive samples that disagree with it.
module msg_fifo_debounce #(
    parameter int CKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic ckd_o
);
    localparam int CW = $clog2(CKS + 1);
    localparam logic [CW-1:0] LAST = CW'(CKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (raw_i != lvl_q) begin
            if (cnt_q == LAST) lvl_d = raw_i;
            else               cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign ckd_o = lvl_q;
endmodule

`ifdef MSG_FIFO_REDUN_CHK_EN
// Redundancy code: bit i of {src,dst,dat} is folded by XOR into red bit (i mod RSZ).
module calc_redun #(
    parameter int ASZ = 8,
    parameter int DSZ = 16,
    parameter int RSZ = 4
) (
    input  logic [ASZ-1:0] src_i,
    input  logic [ASZ-1:0] dst_i,
    input  logic [DSZ-1:0] dat_i,
    output logic [RSZ-1:0] red_o
);
    localparam int W = 2 * ASZ + DSZ;
    logic [W-1:0] bits;

    always_comb begin
        bits  = {src_i, dst_i, dat_i};
        red_o = '0;
        for (int i = 0; i < W; i++) red_o[i % RSZ] = red_o[i % RSZ] ^ bits[i];
    end
endmodule
`endif

module msg_fifo #(
    parameter int ASZ         = `NS_ADDRESS_SIZE,
    parameter int DSZ         = `NS_DATA_SIZE,
    parameter int RSZ         = `NS_REDUN_SIZE,
    parameter int DEPTH       = 4,
    parameter int RCV_REQ_CKS = `NS_REQ_CKS,
    parameter int SND_ACK_CKS = `NS_ACK_CKS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ASZ-1:0]           i0_src,
    input  logic [ASZ-1:0]           i0_dst,
    input  logic [DSZ-1:0]           i0_dat,
    input  logic [RSZ-1:0]           i0_red,
    input  logic                     i0_req,
    output logic                     i0_ack,
    output logic [ASZ-1:0]           o0_src,
    output logic [ASZ-1:0]           o0_dst,
    output logic [DSZ-1:0]           o0_dat,
    output logic [RSZ-1:0]           o0_red,
    output logic                     o0_req,
    input  logic                     o0_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);
    localparam int MW = 2 * ASZ + DSZ + RSZ;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_DONE} tx_state_t;

    rx_state_t     rx_q, rx_d;
    tx_state_t     tx_q, tx_d;
    logic [MW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ack_q, ack_d, req_q, req_d;
    logic [MW-1:0] out_q, out_d;
    logic          ckd_req, ckd_ack, push, pop;

    msg_fifo_debounce #(.CKS(RCV_REQ_CKS)) u_req_db (
        .clk(clk), .reset(reset), .raw_i(i0_req), .ckd_o(ckd_req));
    msg_fifo_debounce #(.CKS(SND_ACK_CKS)) u_ack_db (
        .clk(clk), .reset(reset), .raw_i(o0_ack), .ckd_o(ckd_ack));

`ifdef MSG_FIFO_REDUN_CHK_EN
    logic [RSZ-1:0] red_calc;
    logic           red_ok;
    logic           err_q, err_d;

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_redun (
        .src_i(i0_src), .dst_i(i0_dst), .dat_i(i0_dat), .red_o(red_calc));
    assign red_ok = (red_calc == i0_red);
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

    // Receive side: a corrupt message is acked but never stored, so it bypasses the full check.
    always_comb begin
        rx_d  = rx_q;
        ack_d = ack_q;
        push  = 1'b0;
`ifdef MSG_FIFO_REDUN_CHK_EN
        err_d = err_q;
`endif
        case (rx_q)
            RX_IDLE: begin
                if (ckd_req) begin
`ifdef MSG_FIFO_REDUN_CHK_EN
                    if (!red_ok) begin
                        ack_d = 1'b1;
                        rx_d  = RX_ACK;
                        err_d = 1'b1;
                    end else
`endif
                    if (!full) begin
                        push  = 1'b1;
                        ack_d = 1'b1;
                        rx_d  = RX_ACK;
                    end
                end
            end
            RX_ACK: begin
                if (!ckd_req) begin
                    ack_d = 1'b0;
                    rx_d  = RX_IDLE;
                end
            end
            default: rx_d = RX_IDLE;
        endcase
    end

    // Transmit side: the head slot is latched into out_q so o0_* stay frozen for the whole handshake.
    always_comb begin
        tx_d  = tx_q;
        req_d = req_q;
        out_d = out_q;
        pop   = 1'b0;
        case (tx_q)
            TX_IDLE: begin
                if (!empty && !ckd_ack) begin
                    out_d = mem_q[rd_ptr_q];
                    req_d = 1'b1;
                    tx_d  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (ckd_ack) begin
                    req_d = 1'b0;
                    pop   = 1'b1;
                    tx_d  = TX_DONE;
                end
            end
            TX_DONE: begin
                if (!ckd_ack) tx_d = TX_IDLE;
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q     <= RX_IDLE;
            tx_q     <= TX_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            out_q    <= '0;
`ifdef MSG_FIFO_REDUN_CHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            req_q    <= req_d;
            out_q    <= out_d;
`ifdef MSG_FIFO_REDUN_CHK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Slot storage needs no reset: contents are only visible once the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {i0_src, i0_dst, i0_dat, i0_red};
    end

    assign {o0_src, o0_dst, o0_dat, o0_red} = out_q;
    assign i0_ack = ack_q;
    assign o0_req = req_q;
    assign count  = count_q;
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
endmodule

// File: doc/msg_fifo.md
Name: msg_fifo

Overview:
- Single-clock message buffer between two 4-phase req/ack channels.
- Responder on input channel i0: accepts src/dst/dat/red messages and acks them.
- Initiator on output channel o0: re-sends stored messages in arrival order.
- Sits between a channel source and sink in the test fabric; decouples them by DEPTH messages.

Parameters:
- ASZ, `NS_ADDRESS_SIZE, width of src and dst fields
- DSZ, `NS_DATA_SIZE, width of dat field
- RSZ, `NS_REDUN_SIZE, width of red field
- DEPTH, 4, number of message slots; power of 2, minimum 2
- RCV_REQ_CKS, `NS_REQ_CKS, consecutive equal samples needed to accept an i0_req level change
- SND_ACK_CKS, `NS_ACK_CKS, consecutive equal samples needed to accept an o0_ack level change

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i0_src  in  ASZ  input message source
- i0_dst  in  ASZ  input message destination
- i0_dat  in  DSZ  input message data
- i0_red  in  RSZ  input message redundancy
- i0_req  in  1  input request
- i0_ack  out  1  input acknowledge
- o0_src  out  ASZ  output message source
- o0_dst  out  ASZ  output message destination
- o0_dat  out  DSZ  output message data
- o0_red  out  RSZ  output message redundancy
- o0_req  out  1  output request
- o0_ack  in  1  output acknowledge
- count  out  $clog2(DEPTH)+1  messages currently stored
- full  out  1  count==DEPTH
- empty  out  1  count==0
- err  out  1  sticky redundancy error (only with the optional feature)

Behaviour:
- Reset (async, active-high): all outputs 0; pointers 0; both FSMs idle; debouncer state 0; empty=1.
- Debounce, i0_req -> ckd_req: the filtered level changes only after RCV_REQ_CKS consecutive identical raw samples.
- Debounce, o0_ack -> ckd_ack: same rule with SND_ACK_CKS.
- RX FSM, RX_IDLE:
  - If ckd_req && !full: write {i0_src,i0_dst,i0_dat,i0_red} at wr_ptr, wr_ptr++, i0_ack<=1, go RX_ACK.
  - If ckd_req && full: hold; i0_ack stays 0 (backpressure).
- RX FSM, RX_ACK: when !ckd_req, i0_ack<=0, go RX_IDLE. Input fields are ignored here.
- TX FSM, TX_IDLE: if !empty && !ckd_ack, load o0_* registers from the head slot, o0_req<=1, go TX_WAIT.
- TX FSM, TX_WAIT: o0_* held stable. When ckd_ack: o0_req<=0, rd_ptr++ (pop), go TX_DONE.
- TX FSM, TX_DONE: when !ckd_ack, go TX_IDLE.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count: push and pop in the same cycle leaves count unchanged. It never exceeds DEPTH and never underflows.
- Latency, empty FIFO: raw i0_req rises at cycle t -> i0_ack=1 at t+RCV_REQ_CKS+1 -> o0_req=1 one cycle later.
- Ordering: strict FIFO. Messages pass through unmodified (red is forwarded, not recomputed).
- A message is popped only on ckd_ack during TX_WAIT. o0_* never change while o0_req=1.
- Full: a push becomes possible in the cycle after count drops below DEPTH.
- Reset mid-handshake: req/ack drop immediately and stored messages are discarded. Peers must restart with req low.

Optional Feature:
- Macro: MSG_FIFO_REDUN_CHK_EN.
- Defined:
  - Instantiate calc_redun on i0_src/i0_dst/i0_dat.
  - In RX_IDLE on ckd_req, if i0_red differs from the computed value: ack normally (i0_ack<=1, go RX_ACK) but do not store the message, and set err<=1. err clears only on reset.
  - A bad message is accepted even when full.
- Undefined: err is tied to 0, no check logic is built, and every message is stored.

Test Plan:
- Single message (DEPTH=4, CKS=2): send src=0, dst=1, dat=5, red=correct; o0 holds ack low then acks -> i0_ack=1 at t+3; o0 shows identical fields with o0_req=1; count returns 0 after ack.
- Ordering: send dat=0..7 with o0_ack tied low -> i0 accepts 4, full=1, 5th req is not acked. Then release o0 -> output order is 0..7, no loss or duplication.
- Simultaneous push/pop: count=2; input handshake completes in the same cycle as output ckd_ack -> count stays 2.
- Glitch rejection (CKS=3): i0_req high for 2 cycles then low -> no ack, count=0. o0_ack glitch of 1 cycle during TX_WAIT -> no pop, o0_req stays 1.
- Redundancy (MSG_FIFO_REDUN_CHK_EN defined): send dat=9 with wrong red -> acked, count=0, err=1; next good message dat=10 is stored and forwarded, err stays 1. Without the macro, the same message is forwarded and err=0.
- Reset mid-operation: assert reset with count=3 and o0_req=1 -> outputs 0 asynchronously, empty=1. After release the FIFO is fully functional with a fresh message dat=3.
